// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receiver: register map, parity modes,
// receive FSM encoding and register bit positions.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int DATA_EMPTY_BIT = 8;
  localparam int DATA_FE_BIT    = 9;
  localparam int DATA_PE_BIT    = 10;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVR_BIT   = 10;

  localparam logic [15:0] MIN_DIV = 16'd4;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fill count; a pop on empty is ignored and a push on
// full succeeds only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign overrun_o = push_i & ~do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver on the PicoRV32 native bus: runtime baud divider, mid-bit
// sampling, optional parity, and a receive FIFO with per-character error flags.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int DEFAULT_DIV = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serial_in,
  output logic        rx_irq
);

  localparam int FW = DATA_BITS + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Synchroniser resets low so a line already low out of reset is not
  // mistaken for a start edge; a real 1->0 transition is required.
  logic [1:0]  sync_q;
  logic        rx_s, rx_prev_q;

  rx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] divl_q, divl_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic        pe_q, pe_d, fe_q, fe_d;
  logic        push_q, push_d;

  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d;
  logic        ready_q, irq_q;

  logic          acc, wr, rd;
  logic [1:0]    reg_sel;
  logic          fifo_pop, fifo_full, fifo_empty, fifo_ovr;
  logic [FW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   data_w, stat_w, rdata_w;
  logic          unused_bits;

  assign rx_s        = sync_q[1];
  assign unused_bits = ^{mem_instr, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};

  assign reg_sel  = mem_addr[3:2];
  assign acc      = ready_q & mem_valid & enable;
  assign wr       = acc & (|mem_wstrb);
  assign rd       = acc & ~(|mem_wstrb);
  assign fifo_pop = rd & (reg_sel == REG_DATA);

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .push_i    (push_q),
    .wdata_i   ({pe_q, fe_q, shreg_q}),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .overrun_o (fifo_ovr)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    divl_d   = divl_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    push_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (rx_prev_q && !rx_s) begin
          divl_d  = div_q;
          pe_d    = 1'b0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (timer_q == (divl_q >> 1)) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            timer_d  = '0;
            bitcnt_d = '0;
            state_d  = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (timer_q == divl_q - 16'd1) begin
          timer_d  = '0;
          shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'(DATA_BITS - 1))
            state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (timer_q == divl_q - 16'd1) begin
          timer_d = '0;
          // Odd mode flips the sense: an odd total of ones is correct.
          pe_d    = ^{shreg_q, rx_s, (PARITY == PARITY_ODD)};
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer_q == divl_q - 16'd1) begin
          fe_d    = ~rx_s;
          push_d  = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (wr && reg_sel == REG_DIV) div_d = clamp_div(mem_wdata[15:0]);
    ovr_d = ovr_q;
    if (wr && reg_sel == REG_STATUS && mem_wdata[STAT_OVR_BIT]) ovr_d = 1'b0;
    if (fifo_ovr) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q    <= '0;
      rx_prev_q <= 1'b0;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      divl_q    <= 16'(DEFAULT_DIV);
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      push_q    <= 1'b0;
      div_q     <= 16'(DEFAULT_DIV);
      ovr_q     <= 1'b0;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], serial_in};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      timer_q   <= timer_d;
      divl_q    <= divl_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      push_q    <= push_d;
      div_q     <= div_d;
      ovr_q     <= ovr_d;
      ready_q   <= mem_valid & enable & ~ready_q;
      irq_q     <= ~fifo_empty | ovr_q;
    end
  end

  always_comb begin
    data_w = '0;
    stat_w = '0;
    if (fifo_empty) begin
      data_w[DATA_EMPTY_BIT] = 1'b1;
    end else begin
      data_w[DATA_BITS-1:0] = fifo_head[DATA_BITS-1:0];
      data_w[DATA_FE_BIT]   = fifo_head[DATA_BITS];
      data_w[DATA_PE_BIT]   = fifo_head[DATA_BITS+1];
    end
    stat_w[CW-1:0]        = fifo_count;
    stat_w[STAT_FULL_BIT] = fifo_full;
    stat_w[STAT_OVR_BIT]  = ovr_q;
    unique case (reg_sel)
      REG_DATA:   rdata_w = data_w;
      REG_STATUS: rdata_w = stat_w;
      REG_DIV:    rdata_w = {16'd0, div_q};
      default:    rdata_w = '0;
    endcase
  end

  assign mem_rdata = enable ? rdata_w : 32'd0;
  assign mem_ready = ready_q;
  assign rx_irq    = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo (8 data bits, even parity,
// 4-entry FIFO) against a queue-based model of received characters.
module tb_uart_rx_fifo;

  localparam int DEF_DIV = 20;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        resetn, enable, mem_valid, mem_instr, serial_in;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_ready, rx_irq;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  bit          ovr_m;
  int          div_m;
  logic [31:0] rdv;

  uart_rx_fifo #(.DEFAULT_DIV(DEF_DIV), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .serial_in(serial_in), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
    end
  endtask

  task automatic bus_xfer(input logic [1:0] r, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] d);
    int n;
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_wstrb = strb; mem_wdata = wd;
    mem_addr = {28'd0, r, 2'b00};
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 20);
    chk("bus_ready", {31'd0, mem_ready}, 32'd1);
    d = mem_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'd0;
    chk("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    bus_xfer(r, 4'd0, 32'd0, d);
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(r, 4'hf, wd, dummy);
  endtask

  task automatic drive_bit(input bit b);
    serial_in = b;
    repeat (div_m) @(negedge clk);
  endtask

  // Reference: a character is {pe, fe, data}; pe is set when the total ones
  // count over data + parity bit is odd, fe when the stop bit is low.
  task automatic model_push(input logic [7:0] d, input bit pb, input bit sb);
    logic [31:0] w;
    w = {21'd0, ((^d) ^ pb), ~sb, 1'b0, d};
    if (exp_q.size() == DEPTH) ovr_m = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pb, input bit sb, input bit leave_low);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(sb);
    if (!leave_low) begin
      serial_in = 1'b1;
      repeat (2 * div_m) @(negedge clk);
    end
    model_push(d, pb, sb);
  endtask

  function automatic logic [31:0] exp_status();
    return {21'd0, ovr_m, (exp_q.size() == DEPTH), 9'(exp_q.size())};
  endfunction

  task automatic read_data_chk(input string tag);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
    bus_read(2'd0, rdv);
    chk(tag, rdv, e);
  endtask

  task automatic irq_chk(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, {31'd0, rx_irq}, {31'd0, (exp_q.size() != 0) | ovr_m});
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_wstrb = 4'd0; mem_wdata = '0; mem_addr = '0; serial_in = 1'b1;
    div_m = DEF_DIV; ovr_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_irq", {31'd0, rx_irq}, 32'd0);
    resetn = 1'b1;
    bus_read(2'd1, rdv); chk("rst_status", rdv, exp_status());
    bus_read(2'd2, rdv); chk("rst_div", rdv, DEF_DIV);
    read_data_chk("rst_data_empty");
    bus_read(2'd3, rdv); chk("reg3_zero", rdv, 32'd0);

    // Basic frame at div 16
    bus_write(2'd2, 32'd16); div_m = 16;
    bus_read(2'd2, rdv); chk("div16", rdv, 32'd16);
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
    chk("irq_after_rx", {31'd0, rx_irq}, 32'd1);
    read_data_chk("data_a5");
    read_data_chk("data_empty_after");
    irq_chk("irq_after_pop");

    // Short low glitch must be rejected as a false start
    @(negedge clk); serial_in = 1'b0;
    repeat (5) @(negedge clk); serial_in = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(2'd1, rdv); chk("glitch_status", rdv, exp_status());

    // Parity error
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    read_data_chk("parity_err");

    // Framing error, line held low afterwards
    send_frame(8'h55, ^8'h55, 1'b0, 1'b1);
    repeat (3 * div_m) @(negedge clk);
    bus_read(2'd1, rdv); chk("stuck_low_status", rdv, exp_status());
    serial_in = 1'b1;
    repeat (2 * div_m) @(negedge clk);
    read_data_chk("framing_err");

    // Randomized frames, divisors and error injection
    for (int it = 0; it < 6; it++) begin
      int nf;
      div_m = $urandom_range(16, 24);
      bus_write(2'd2, div_m);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        logic [7:0] d;
        d = 8'($urandom);
        send_frame(d, (^d) ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), 1'b0);
      end
      bus_read(2'd1, rdv); chk("rand_status", rdv, exp_status());
      for (int f = 0; f <= nf; f++) read_data_chk("rand_data");
    end

    // Overrun with a 4-entry FIFO
    div_m = 16; bus_write(2'd2, 32'd16);
    for (int f = 1; f <= 5; f++) send_frame(8'(f), ^(8'(f)), 1'b1, 1'b0);
    bus_read(2'd1, rdv); chk("ovr_status", rdv, exp_status());
    chk("ovr_status_const", rdv, 32'h604);
    @(negedge clk); enable = 1'b0; mem_addr = 32'h4; #1;
    chk("rdata_disabled", mem_rdata, 32'd0);
    for (int f = 0; f < 4; f++) read_data_chk("ovr_data");
    irq_chk("irq_ovr_held");
    bus_write(2'd1, 32'h400); ovr_m = 1'b0;
    bus_read(2'd1, rdv); chk("ovr_cleared", rdv, exp_status());
    irq_chk("irq_ovr_cleared");

    // Divider clamp
    bus_write(2'd2, 32'd2); bus_read(2'd2, rdv); chk("div_clamp2", rdv, 32'd4);
    bus_write(2'd2, 32'd0); bus_read(2'd2, rdv); chk("div_clamp0", rdv, 32'd4);
    bus_write(2'd2, 32'd5); bus_read(2'd2, rdv); chk("div_5", rdv, 32'd5);

    // Reset in the middle of a frame
    div_m = 16; bus_write(2'd2, 32'd16);
    @(negedge clk);
    serial_in = 1'b0;
    repeat (4 * div_m) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete(); ovr_m = 1'b0; div_m = DEF_DIV;
    repeat (5 * 16) @(negedge clk);
    serial_in = 1'b1;
    repeat (4 * 16) @(negedge clk);
    bus_read(2'd1, rdv); chk("midrst_status", rdv, exp_status());
    bus_read(2'd2, rdv); chk("midrst_div", rdv, DEF_DIV);
    chk("midrst_irq", {31'd0, rx_irq}, 32'd0);
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0);
    read_data_chk("post_rst_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
